// File: rtl/mac_operand_stage.sv
// MAC operand stage: two-entry skid buffer that registers lane operands and
// precomputes per-group product-sign flags. Define MAC_ZERO_DETECT_EN to clear
// a group's flag when either of its operands is all-zero.
module mac_operand_stage #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAC_CONF_WIDTH-1:0] in_cfg,
    input  logic [MAC_MIN_WIDTH-1:0]  A0_in,
    input  logic [MAC_MIN_WIDTH-1:0]  A1_in,
    input  logic [MAC_MIN_WIDTH-1:0]  A2_in,
    input  logic [MAC_MIN_WIDTH-1:0]  A3_in,
    input  logic [MAC_MIN_WIDTH-1:0]  B0_in,
    input  logic [MAC_MIN_WIDTH-1:0]  B1_in,
    input  logic [MAC_MIN_WIDTH-1:0]  B2_in,
    input  logic [MAC_MIN_WIDTH-1:0]  B3_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_CONF_WIDTH-1:0] cfg,
    output logic [MAC_MIN_WIDTH-1:0]  A0_out,
    output logic [MAC_MIN_WIDTH-1:0]  A1_out,
    output logic [MAC_MIN_WIDTH-1:0]  A2_out,
    output logic [MAC_MIN_WIDTH-1:0]  A3_out,
    output logic [MAC_MIN_WIDTH-1:0]  B0_out,
    output logic [MAC_MIN_WIDTH-1:0]  B1_out,
    output logic [MAC_MIN_WIDTH-1:0]  B2_out,
    output logic [MAC_MIN_WIDTH-1:0]  B3_out,
    output logic                      A0B0_neg,
    output logic                      A1B1_neg,
    output logic                      A2B2_neg,
    output logic                      A3B3_neg,
    output logic [15:0]               beat_cnt
);

    localparam int W   = MAC_MIN_WIDTH;
    localparam int MSB = MAC_MIN_WIDTH - 1;

    logic [4*W-1:0]            w_inA;
    logic [4*W-1:0]            w_inB;
    logic [3:0]                w_laneNeg;
    logic [3:0]                w_laneZero;
    logic [1:0]                w_pairZero;
    logic                      w_quadZero;
    logic [3:0]                w_negFlags;
    logic                      w_accept;
    logic                      w_transfer;
    logic                      w_skidFullNext;

    logic                      r_mainValid;
    logic [MAC_CONF_WIDTH-1:0] r_mainCfg;
    logic [4*W-1:0]            r_mainA;
    logic [4*W-1:0]            r_mainB;
    logic [3:0]                r_mainNeg;

    logic                      r_skidValid;
    logic [MAC_CONF_WIDTH-1:0] r_skidCfg;
    logic [4*W-1:0]            r_skidA;
    logic [4*W-1:0]            r_skidB;
    logic [3:0]                r_skidNeg;

    logic                      r_inReady;
    logic [15:0]               r_beatCnt;

    assign w_inA = {A3_in, A2_in, A1_in, A0_in};
    assign w_inB = {B3_in, B2_in, B1_in, B0_in};

    assign w_accept   = in_valid & r_inReady & en;
    assign w_transfer = r_mainValid & out_ready & en;

    assign w_laneNeg[0] = A0_in[MSB] ^ B0_in[MSB];
    assign w_laneNeg[1] = A1_in[MSB] ^ B1_in[MSB];
    assign w_laneNeg[2] = A2_in[MSB] ^ B2_in[MSB];
    assign w_laneNeg[3] = A3_in[MSB] ^ B3_in[MSB];

`ifdef MAC_ZERO_DETECT_EN
    assign w_laneZero[0] = (A0_in == '0) | (B0_in == '0);
    assign w_laneZero[1] = (A1_in == '0) | (B1_in == '0);
    assign w_laneZero[2] = (A2_in == '0) | (B2_in == '0);
    assign w_laneZero[3] = (A3_in == '0) | (B3_in == '0);
    assign w_pairZero[0] = ({A1_in, A0_in} == '0) | ({B1_in, B0_in} == '0);
    assign w_pairZero[1] = ({A3_in, A2_in} == '0) | ({B3_in, B2_in} == '0);
    assign w_quadZero    = (w_inA == '0) | (w_inB == '0);
`else
    assign w_laneZero = '0;
    assign w_pairZero = '0;
    assign w_quadZero = 1'b0;
`endif

    // Sign flags: only the top lane of each wide group carries the operand sign.
    always_comb begin
        w_negFlags = '0;
        if (in_cfg[3]) begin
            case (in_cfg[1:0])
                2'b10: begin
                    w_negFlags[3] = w_laneNeg[3] & ~w_quadZero;
                end
                2'b01: begin
                    w_negFlags[1] = w_laneNeg[1] & ~w_pairZero[0];
                    w_negFlags[3] = w_laneNeg[3] & ~w_pairZero[1];
                end
                default: begin
                    w_negFlags = w_laneNeg & ~w_laneZero;
                end
            endcase
        end
    end

    always_comb begin
        w_skidFullNext = r_skidValid;
        if (r_skidValid && w_transfer) begin
            w_skidFullNext = 1'b0;
        end else if (!r_skidValid && w_accept && r_mainValid && !w_transfer) begin
            w_skidFullNext = 1'b1;
        end
    end

    // Main register: refilled from skid first so beats leave in arrival order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mainValid <= 1'b0;
            r_mainCfg   <= '0;
            r_mainA     <= '0;
            r_mainB     <= '0;
            r_mainNeg   <= '0;
        end else if (en) begin
            if (w_transfer) begin
                if (r_skidValid) begin
                    r_mainValid <= 1'b1;
                    r_mainCfg   <= r_skidCfg;
                    r_mainA     <= r_skidA;
                    r_mainB     <= r_skidB;
                    r_mainNeg   <= r_skidNeg;
                end else if (w_accept) begin
                    r_mainValid <= 1'b1;
                    r_mainCfg   <= in_cfg;
                    r_mainA     <= w_inA;
                    r_mainB     <= w_inB;
                    r_mainNeg   <= w_negFlags;
                end else begin
                    r_mainValid <= 1'b0;
                end
            end else if (w_accept && !r_mainValid) begin
                r_mainValid <= 1'b1;
                r_mainCfg   <= in_cfg;
                r_mainA     <= w_inA;
                r_mainB     <= w_inB;
                r_mainNeg   <= w_negFlags;
            end
        end
    end

    // Skid register only fills while main is stalled; in_ready keeps it from overflowing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skidValid <= 1'b0;
            r_skidCfg   <= '0;
            r_skidA     <= '0;
            r_skidB     <= '0;
            r_skidNeg   <= '0;
        end else if (en) begin
            r_skidValid <= w_skidFullNext;
            if (!r_skidValid && w_accept && r_mainValid && !w_transfer) begin
                r_skidCfg <= in_cfg;
                r_skidA   <= w_inA;
                r_skidB   <= w_inB;
                r_skidNeg <= w_negFlags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inReady <= 1'b0;
            r_beatCnt <= '0;
        end else if (en) begin
            r_inReady <= ~w_skidFullNext;
            if (w_transfer && (r_beatCnt != 16'hFFFF)) begin
                r_beatCnt <= r_beatCnt + 16'd1;
            end
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_mainValid;
    assign cfg       = r_mainCfg;
    assign beat_cnt  = r_beatCnt;

    assign A0_out = r_mainA[0*W +: W];
    assign A1_out = r_mainA[1*W +: W];
    assign A2_out = r_mainA[2*W +: W];
    assign A3_out = r_mainA[3*W +: W];
    assign B0_out = r_mainB[0*W +: W];
    assign B1_out = r_mainB[1*W +: W];
    assign B2_out = r_mainB[2*W +: W];
    assign B3_out = r_mainB[3*W +: W];

    assign A0B0_neg = r_mainNeg[0];
    assign A1B1_neg = r_mainNeg[1];
    assign A2B2_neg = r_mainNeg[2];
    assign A3B3_neg = r_mainNeg[3];

endmodule

// File: tb/tb_mac_operand_stage.sv
// Directed self-checking bench for mac_operand_stage: flag decode per mode,
// skid backpressure ordering, enable freeze and asynchronous reset.
module tb_mac_operand_stage;

    logic        clk;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cfg;
    logic [31:0] aVec;
    logic [31:0] bVec;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  cfg;
    logic [7:0]  A0_out, A1_out, A2_out, A3_out;
    logic [7:0]  B0_out, B1_out, B2_out, B3_out;
    logic        A0B0_neg, A1B1_neg, A2B2_neg, A3B3_neg;
    logic [15:0] beat_cnt;
    logic [3:0]  negVec;

    int checkCount;
    int errorCount;
    int expCnt;

    mac_operand_stage dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cfg    (in_cfg),
        .A0_in     (aVec[7:0]),
        .A1_in     (aVec[15:8]),
        .A2_in     (aVec[23:16]),
        .A3_in     (aVec[31:24]),
        .B0_in     (bVec[7:0]),
        .B1_in     (bVec[15:8]),
        .B2_in     (bVec[23:16]),
        .B3_in     (bVec[31:24]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg       (cfg),
        .A0_out    (A0_out),
        .A1_out    (A1_out),
        .A2_out    (A2_out),
        .A3_out    (A3_out),
        .B0_out    (B0_out),
        .B1_out    (B1_out),
        .B2_out    (B2_out),
        .B3_out    (B3_out),
        .A0B0_neg  (A0B0_neg),
        .A1B1_neg  (A1B1_neg),
        .A2B2_neg  (A2B2_neg),
        .A3B3_neg  (A3B3_neg),
        .beat_cnt  (beat_cnt)
    );

    assign negVec = {A3B3_neg, A2B2_neg, A1B1_neg, A0B0_neg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = valid;
        in_cfg   = c;
        aVec     = a;
        bVec     = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        expCnt     = 0;
        rst        = 1'b0;
        en         = 1'b1;
        out_ready  = 1'b1;
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);

        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_beat_cnt", {16'd0, beat_cnt}, 32'd0);
        tick();
        tick();
        checkOutput("rst_in_ready_held", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_cfg", {28'd0, cfg}, 32'd0);
        checkOutput("rst_A0", {24'd0, A0_out}, 32'd0);
        checkOutput("rst_flags", {28'd0, negVec}, 32'd0);
        rst = 1'b1;
        tick();
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("release_out_valid", {31'd0, out_valid}, 32'd0);

        // Signed single-lane beat
        applyStimulus(1'b1, 4'b1000, 32'h0000_7F80, 32'h0000_7F01);
        tick();
        checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("single_flags", {28'd0, negVec}, 32'h1);
        checkOutput("single_A0", {24'd0, A0_out}, 32'h80);
        checkOutput("single_B1", {24'd0, B1_out}, 32'h7F);
        checkOutput("single_cfg", {28'd0, cfg}, 32'h8);

        // Signed dual beat, streamed back-to-back
        applyStimulus(1'b1, 4'b1001, 32'h0000_FF01, 32'h8000_0001);
        tick();
        expCnt = 1;
`ifdef MAC_ZERO_DETECT_EN
        checkOutput("dual_flags", {28'd0, negVec}, 32'h2);
`else
        checkOutput("dual_flags", {28'd0, negVec}, 32'hA);
`endif
        checkOutput("dual_cnt", {16'd0, beat_cnt}, expCnt);
        checkOutput("dual_A1", {24'd0, A1_out}, 32'hFF);

        applyStimulus(1'b1, 4'b1001, 32'h0000_FF01, 32'h8000_0000);
        tick();
        expCnt = 2;
`ifdef MAC_ZERO_DETECT_EN
        checkOutput("dual_zeroB_flags", {28'd0, negVec}, 32'h0);
`else
        checkOutput("dual_zeroB_flags", {28'd0, negVec}, 32'hA);
`endif

        applyStimulus(1'b1, 4'b0010, 32'hFF00_0000, 32'h0100_0000);
        tick();
        expCnt = 3;
        checkOutput("quad_unsigned_flags", {28'd0, negVec}, 32'h0);
        checkOutput("quad_unsigned_cfg", {28'd0, cfg}, 32'h2);

        applyStimulus(1'b1, 4'b1010, 32'hFF01_0180, 32'h0101_0101);
        tick();
        expCnt = 4;
        checkOutput("quad_signed_flags", {28'd0, negVec}, 32'h8);

        applyStimulus(1'b1, 4'b1011, 32'h0180_0180, 32'h8001_0101);
        tick();
        expCnt = 5;
        checkOutput("single11_flags", {28'd0, negVec}, 32'hD);
        checkOutput("stream_cnt", {16'd0, beat_cnt}, expCnt);

        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        expCnt = 6;
        checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("drain_cnt", {16'd0, beat_cnt}, expCnt);

        // Backpressure: beat 1 held, beat 2 in skid, beat 3 refused
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'h0, 32'h1, 32'h0);
        tick();
        checkOutput("bp_in_ready1", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 4'h0, 32'h2, 32'h0);
        tick();
        checkOutput("bp_in_ready2", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_hold1_A0", {24'd0, A0_out}, 32'h1);
        applyStimulus(1'b1, 4'h0, 32'h3, 32'h0);
        tick();
        checkOutput("bp_hold2_A0", {24'd0, A0_out}, 32'h1);
        checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_in_ready3", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_cnt", {16'd0, beat_cnt}, expCnt);
        out_ready = 1'b1;
        tick();
        expCnt = 7;
        checkOutput("bp_order2_A0", {24'd0, A0_out}, 32'h2);
        checkOutput("bp_ready_again", {31'd0, in_ready}, 32'd1);
        tick();
        expCnt = 8;
        checkOutput("bp_order3_A0", {24'd0, A0_out}, 32'h3);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        expCnt = 9;
        checkOutput("bp_cnt_final", {16'd0, beat_cnt}, expCnt);
        checkOutput("bp_empty", {31'd0, out_valid}, 32'd0);

        // Enable low freezes everything mid-stream
        applyStimulus(1'b1, 4'h0, 32'h4, 32'h0);
        tick();
        en = 1'b0;
        applyStimulus(1'b1, 4'h0, 32'h5, 32'h0);
        tick();
        tick();
        checkOutput("en_hold_A0", {24'd0, A0_out}, 32'h4);
        checkOutput("en_hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("en_hold_cnt", {16'd0, beat_cnt}, expCnt);
        checkOutput("en_hold_ready", {31'd0, in_ready}, 32'd1);
        en = 1'b1;
        tick();
        expCnt = 10;
        checkOutput("en_resume_A0", {24'd0, A0_out}, 32'h5);
        checkOutput("en_resume_cnt", {16'd0, beat_cnt}, expCnt);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        expCnt = 11;
        checkOutput("en_drain_cnt", {16'd0, beat_cnt}, expCnt);

        // Asynchronous reset with both entries full
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'b1000, 32'h80, 32'h01);
        tick();
        applyStimulus(1'b1, 4'h0, 32'h8, 32'h0);
        tick();
        checkOutput("full_in_ready", {31'd0, in_ready}, 32'd0);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_cnt", {16'd0, beat_cnt}, 32'd0);
        checkOutput("async_A0", {24'd0, A0_out}, 32'd0);
        checkOutput("async_flags", {28'd0, negVec}, 32'd0);
        checkOutput("async_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        checkOutput("rerelease_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rerelease_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rerelease_cnt", {16'd0, beat_cnt}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mac_operand_stage.md
MAC_OPERAND_STAGE -- requirements
Module: mac_operand_stage

Interface
REQ-001 SHALL have parameter MAC_CONF_WIDTH, default 4, meaning cfg width: bit 3 signed, bit 2 mac/mul, bits 1:0 single/dual/quad.
REQ-002 SHALL have parameter MAC_MIN_WIDTH, default 8, meaning lane operand width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  stage enable; low freezes all state.
REQ-006 SHALL have port in_valid  input  1  upstream beat present.
REQ-007 SHALL have port in_ready  output  1  stage can accept a beat.
REQ-008 SHALL have port in_cfg  input  MAC_CONF_WIDTH  per-beat configuration.
REQ-009 SHALL have ports A0_in..A3_in, B0_in..B3_in  input  MAC_MIN_WIDTH each  lane operands.
REQ-010 SHALL have port out_valid  output  1  registered beat present.
REQ-011 SHALL have port out_ready  input  1  downstream (negator/multiplier) accepts beat.
REQ-012 SHALL have port cfg  output  MAC_CONF_WIDTH  registered cfg of the output beat.
REQ-013 SHALL have ports A0_out..A3_out, B0_out..B3_out  output  MAC_MIN_WIDTH each  registered operands.
REQ-014 SHALL have ports A0B0_neg, A1B1_neg, A2B2_neg, A3B3_neg  output  1 each  product-negative flags.
REQ-015 SHALL have port beat_cnt  output  16  count of output transfers.

Function
REQ-016 SHALL accept a beat when in_valid & in_ready & en; SHALL transfer out when out_valid & out_ready & en.
REQ-017 SHALL be a 2-entry skid buffer (main + skid register); latency accept-to-out_valid 1 cycle; sustained throughput 1 beat/cycle with out_ready high.
REQ-018 SHALL drive in_ready = ~skid_full, registered (no combinational path from out_ready).
REQ-019 SHALL, when main is full and not transferring and a beat is accepted, store it in skid; on next main transfer SHALL move skid to main; skid SHALL never be written while full.
REQ-020 SHALL present beats in acceptance order; simultaneous accept and transfer with skid empty SHALL load main directly.
REQ-021 SHALL decode mode from in_cfg[1:0]: 10 quad, 01 dual, 00 or 11 single.
REQ-022 SHALL compute flags at acceptance, stored with beat, using sgn = in_cfg[3] and msb = bit MAC_MIN_WIDTH-1:
REQ-023 single: AiBi_neg = sgn & (Ai msb ^ Bi msb) for i=0..3.
REQ-024 dual: A1B1_neg from lane 1 msbs, A3B3_neg from lane 3 msbs; A0B0_neg = A2B2_neg = 0.
REQ-025 quad: A3B3_neg from lane 3 msbs; other flags 0.
REQ-026 SHALL force all flags 0 when sgn = 0.
REQ-027 SHALL increment beat_cnt on each output transfer, saturating at 16'hFFFF.
REQ-028 SHALL, with en low, ignore in_valid/out_ready, hold all registers and outputs, keep in_ready value.
REQ-029 SHALL hold out data/cfg/flags stable while out_valid & ~out_ready.

Reset
REQ-030 SHALL on rst low, immediately: out_valid=0, skid empty, in_ready=0 while asserted, 1 the first cycle after release, beat_cnt=0, all data/cfg/flag outputs 0.
REQ-031 SHALL discard buffered beats on reset mid-operation; no transfer in the reset-release cycle's preceding edge.

Configuration
REQ-032 SHALL support macro MAC_ZERO_DETECT_EN: defined, a group flag SHALL be 0 when the group's A or B operand (lane in single, lanes 1:0 or 3:2 in dual, all lanes in quad) is all-zero; undefined, flags follow REQ-023..026 only.

Verification
REQ-033 Single, in_cfg=4'b1000, A0=8'h80, B0=8'h01, A1=8'h7F, B1=8'h7F, out_ready=1 -> next cycle out_valid=1, A0B0_neg=1, A1B1_neg=0, operands unchanged.
REQ-034 Dual, in_cfg=4'b1001, A1=8'hFF, B1=8'h00, A3=8'h00, B3=8'h80 -> A1B1_neg=1, A3B3_neg=1, A0B0_neg=A2B2_neg=0; with MAC_ZERO_DETECT_EN and all B lanes 1:0 = 0 -> A1B1_neg=0.
REQ-035 Unsigned quad, in_cfg=4'b0010, A3=8'hFF, B3=8'h01 -> all flags 0.
REQ-036 Backpressure: out_ready=0 for 3 cycles, in_valid=1 with beats 1,2,3 -> beat 1 held on outputs, beat 2 in skid, in_ready=0, beat 3 not accepted; release -> beats 1,2,3 in order, beat_cnt=3.
REQ-037 en=0 for 2 cycles mid-stream with out_ready=1 -> no transfer, outputs and beat_cnt frozen, resume without loss.
REQ-038 rst low asynchronously with both entries full -> out_valid=0 and beat_cnt=0 before next clk edge; in_ready=1 one cycle after release.
